// File: rtl/button_event_decoder_if.sv
// Button decoder signal bundle: the debounced button level in, registered event pulses and held level out.
// The master side drives the button; the slave side is the decoder.
interface button_event_decoder_if;
  logic button_i;
  logic press_o;
  logic release_o;
  logic short_click_o;
  logic long_press_o;
  logic repeat_o;
  logic held_o;

  modport master (
    output button_i,
    input  press_o,
    input  release_o,
    input  short_click_o,
    input  long_press_o,
    input  repeat_o,
    input  held_o
  );

  modport slave (
    input  button_i,
    output press_o,
    output release_o,
    output short_click_o,
    output long_press_o,
    output repeat_o,
    output held_o
  );
endinterface

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced level into press/release/short/long pulses and a held level.
// Define BUTTON_AUTO_REPEAT_EN to add periodic repeat pulses while a long press is held.
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 32'd25000000,
  parameter int unsigned REPEAT_CYCLES = 32'd5000000
) (
  input  logic                         clock,
  input  logic                         reset,
  button_event_decoder_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 32'd1);

  // Out-of-range hold/repeat lengths would silently wrap the 26-bit counters.
  if (LONG_CYCLES < 32'd2 || LONG_CYCLES > 32'd67108863) begin : g_long_range_err
    $error("button_event_decoder: LONG_CYCLES must be in 2..2^26-1");
  end
  if (REPEAT_CYCLES < 32'd2 || REPEAT_CYCLES > 32'd67108863) begin : g_repeat_range_err
    $error("button_event_decoder: REPEAT_CYCLES must be in 2..2^26-1");
  end

  state_e      state_q;
  logic        btn_q;
  logic [25:0] hold_cnt_q;
  logic [25:0] hold_cnt_d;
  logic        press_q;
  logic        release_q;
  logic        short_click_q;
  logic        long_press_q;
  logic        held_q;
  logic        rise_edge;
  logic        fall_edge;

  assign rise_edge  = bus.button_i & ~btn_q;
  assign fall_edge  = ~bus.button_i & btn_q;
  assign hold_cnt_d = hold_cnt_q + 26'd1;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYCLES - 32'd1);

  logic [25:0] rep_cnt_q;
  logic [25:0] rep_cnt_d;
  logic        repeat_q;

  assign rep_cnt_d = rep_cnt_q + 26'd1;
`endif

  // Press-tracking FSM; every output is a register so pulses line up with the sampling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      // btn_q = 1 hides a button already held through reset until it is re-pressed.
      state_q       <= IDLE;
      btn_q         <= 1'b1;
      hold_cnt_q    <= 26'd0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_click_q <= 1'b0;
      long_press_q  <= 1'b0;
      held_q        <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q     <= 26'd0;
      repeat_q      <= 1'b0;
`endif
    end else begin
      btn_q         <= bus.button_i;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_click_q <= 1'b0;
      long_press_q  <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rise_edge) begin
            state_q    <= PRESSED;
            press_q    <= 1'b1;
            held_q     <= 1'b1;
            hold_cnt_q <= 26'd0;
          end
        end
        PRESSED: begin
          // A release on the threshold edge still counts as a short click.
          if (fall_edge) begin
            state_q       <= IDLE;
            release_q     <= 1'b1;
            short_click_q <= 1'b1;
            held_q        <= 1'b0;
          end else if (hold_cnt_q == LONG_LAST) begin
            state_q      <= LONG;
            long_press_q <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_cnt_q    <= 26'd0;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        LONG: begin
          if (fall_edge) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          else if (rep_cnt_q == REPEAT_LAST) begin
            repeat_q  <= 1'b1;
            rep_cnt_q <= 26'd0;
          end else begin
            rep_cnt_q <= rep_cnt_d;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_o       = press_q;
  assign bus.release_o     = release_q;
  assign bus.short_click_o = short_click_q;
  assign bus.long_press_o  = long_press_q;
  assign bus.held_o        = held_q;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign bus.repeat_o      = repeat_q;
`else
  assign bus.repeat_o      = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder (LONG_CYCLES=8, REPEAT_CYCLES=4): directed scenarios then random
// button traffic, every cycle compared against a timestamp-based reference model.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  button_event_decoder_if bus ();

  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // reference model: press bookkeeping by edge timestamps
  int cyc = 0;
  bit m_active, m_long, m_prev;
  int m_press_t, m_long_t;
  logic e_press, e_release, e_short, e_long, e_repeat, e_held;

  // per-scenario observations of the DUT
  int prs_cyc, rel_cyc, lng_cyc, first_rep;
  int n_press, n_release, n_short, n_long, n_repeat, n_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_step(input bit b, input bit r);
    cyc++;
    {e_press, e_release, e_short, e_long, e_repeat} = 5'b0;
    if (r) begin
      m_active = 1'b0;
      m_long   = 1'b0;
      m_prev   = 1'b1;
      e_held   = 1'b0;
      return;
    end
    if (!m_active) begin
      if (b && !m_prev) begin
        e_press   = 1'b1;
        m_active  = 1'b1;
        m_long    = 1'b0;
        m_press_t = cyc;
      end
    end else if (!b && m_prev) begin
      e_release = 1'b1;
      e_short   = !m_long;
      m_active  = 1'b0;
      m_long    = 1'b0;
    end else if (!m_long && (cyc - m_press_t) == L) begin
      e_long   = 1'b1;
      m_long   = 1'b1;
      m_long_t = cyc;
    end else if (m_long && REP_EN && ((cyc - m_long_t) % R) == 0) begin
      e_repeat = 1'b1;
    end
    e_held = m_active;
    m_prev = b;
  endtask

  task automatic clear_stats();
    prs_cyc = -1; rel_cyc = -1; lng_cyc = -1; first_rep = -1;
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_repeat = 0; n_held = 0;
  endtask

  task automatic tick(input bit b, input bit r);
    bus.button_i = b;
    reset        = r;
    @(posedge clock);
    model_step(b, r);
    @(negedge clock);
    check("press",       {31'd0, bus.press_o},       {31'd0, e_press});
    check("release",     {31'd0, bus.release_o},     {31'd0, e_release});
    check("short_click", {31'd0, bus.short_click_o}, {31'd0, e_short});
    check("long_press",  {31'd0, bus.long_press_o},  {31'd0, e_long});
    check("repeat",      {31'd0, bus.repeat_o},      {31'd0, e_repeat});
    check("held",        {31'd0, bus.held_o},        {31'd0, e_held});
    if (bus.press_o === 1'b1)       begin n_press++;   prs_cyc = cyc; end
    if (bus.release_o === 1'b1)     begin n_release++; rel_cyc = cyc; end
    if (bus.short_click_o === 1'b1) n_short++;
    if (bus.long_press_o === 1'b1)  begin n_long++;    lng_cyc = cyc; end
    if (bus.repeat_o === 1'b1) begin
      n_repeat++;
      if (first_rep < 0) first_rep = cyc;
    end
    if (bus.held_o === 1'b1) n_held++;
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  initial begin
    bus.button_i = 1'b0;
    reset        = 1'b1;
    m_active = 1'b0; m_long = 1'b0; m_prev = 1'b1;
    m_press_t = 0; m_long_t = 0;
    e_held = 1'b0;
    clear_stats();

    // reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    run(1'b0, 4);

    // short click: 3 cycles high
    clear_stats();
    run(1'b1, 3);
    run(1'b0, 4);
    check("s029_release_delay", rel_cyc - prs_cyc, 3);
    check("s029_short_cnt", n_short, 1);
    check("s029_long_cnt", n_long, 0);

    // long press held 20 cycles; with repeat, the coincident repeat at release is dropped
    clear_stats();
    run(1'b1, 20);
    run(1'b0, 4);
    check("s030_long_delay", lng_cyc - prs_cyc, 8);
    check("s030_release_delay", rel_cyc - prs_cyc, 20);
    check("s030_short_cnt", n_short, 0);
    check("s030_held_cycles", n_held, 20);
    check("s030_repeat_cnt", n_repeat, REP_EN ? 2 : 0);

    // long hold for auto-repeat
    clear_stats();
    run(1'b1, 30);
    run(1'b0, 3);
    check("s031_repeat_cnt", n_repeat, REP_EN ? 5 : 0);
    check("s031_first_repeat", first_rep, REP_EN ? lng_cyc + 4 : -1);

    // release sampled on the threshold edge
    clear_stats();
    run(1'b1, 8);
    run(1'b0, 4);
    check("s032_release_delay", rel_cyc - prs_cyc, 8);
    check("s032_long_cnt", n_long, 0);
    check("s032_short_cnt", n_short, 1);

    // button held through reset deassertion
    clear_stats();
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1);
    run(1'b1, 6);
    check("s033_no_press", n_press, 0);
    run(1'b0, 2);
    run(1'b1, 2);
    check("s033_press_after_repress", n_press, 1);
    run(1'b0, 3);

    // reset while in LONG
    clear_stats();
    run(1'b1, 10);
    tick(1'b1, 1'b1);
    check("s034_held_after_reset", {31'd0, bus.held_o}, 32'd0);
    run(1'b1, 2);
    run(1'b0, 3);
    check("s034_release_cnt", n_release, 0);
    check("s034_short_cnt", n_short, 0);
    run(1'b1, 2);
    check("s034_idle_repress", n_press, 2);
    run(1'b0, 2);

    // random traffic with occasional resets
    for (int i = 0; i < 120; i++) begin
      bit b;
      int len;
      b   = (i % 2 == 0);
      len = $urandom_range(1, 25);
      for (int j = 0; j < len; j++) tick(b, ($urandom_range(0, 150) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
